// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port (instruction fetch / data) arbiter in front of one
//               shared single-port memory. One transaction is in flight at a
//               time: IDLE (arbitrate) -> BUSY (wait for mem_ack_i) -> RESP
//               (one-cycle ack pulse to the granted port) -> IDLE.
//               Ties alternate using a last-grant flag.
// Ports       : clk_i, arst_ni         - clock, async active-low reset
//               imem_req_i/addr_i      - fetch request (read only)
//               imem_rdata_o/ack_o     - fetch response
//               dmem_req_i/we_i/addr_i/wdata_i - data request
//               dmem_rdata_o/ack_o     - data response
//               mem_req_o/we_o/addr_o/wdata_o  - shared memory request
//               mem_rdata_i/ack_i      - shared memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    // instruction fetch port
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    // data port
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    // shared memory port
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic   r_last_dmem;    // 1: most recent grant went to the data port
    logic   r_owner_dmem;   // port owning the transaction in flight
    logic   w_grant;
    logic   w_grant_dmem;
    logic   w_mem_done;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_dmem = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (imem_req_i || dmem_req_i) begin
                    w_grant      = 1'b1;
                    // On a tie the port that did not win last time goes next.
                    w_grant_dmem = dmem_req_i && (!imem_req_i || !r_last_dmem);
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // mem_ack_i only means something while a request is outstanding.
    assign w_mem_done = (r_state == ST_BUSY) && mem_ack_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, payload latch and arbitration history
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_last_dmem  <= 1'b1;
            r_owner_dmem <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            imem_ack_o   <= 1'b0;
            dmem_ack_o   <= 1'b0;
            imem_rdata_o <= '0;
            dmem_rdata_o <= '0;
        end else begin
            // Acks are single-cycle pulses; they are only set on completion.
            imem_ack_o <= 1'b0;
            dmem_ack_o <= 1'b0;

            if (w_grant) begin
                // Payload is frozen here; requester-side changes while the
                // memory is busy are deliberately not tracked.
                r_last_dmem  <= w_grant_dmem;
                r_owner_dmem <= w_grant_dmem;
                mem_req_o    <= 1'b1;
                mem_we_o     <= w_grant_dmem & dmem_we_i;
                mem_addr_o   <= w_grant_dmem ? dmem_addr_i : imem_addr_i;
                mem_wdata_o  <= w_grant_dmem ? dmem_wdata_i : '0;
            end

            if (w_mem_done) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
                // Read data is captured for writes too; the port sees
                // whatever the memory drove in the ack cycle.
                if (r_owner_dmem) begin
                    dmem_ack_o   <= 1'b1;
                    dmem_rdata_o <= mem_rdata_i;
                end else begin
                    imem_ack_o   <= 1'b1;
                    imem_rdata_o <= mem_rdata_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model predicts every output each cycle from the requests and
//               the memory's responses; directed tests pin latency, ordering,
//               stall, payload-freeze and reset behaviour with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 50;

    logic          clk_i   = 1'b0;
    logic          arst_ni = 1'b0;
    logic          imem_req_i = 1'b0;
    logic [AW-1:0] imem_addr_i = '0;
    logic [DW-1:0] imem_rdata_o;
    logic          imem_ack_o;
    logic          dmem_req_i = 1'b0;
    logic          dmem_we_i = 1'b0;
    logic [AW-1:0] dmem_addr_i = '0;
    logic [DW-1:0] dmem_wdata_i = '0;
    logic [DW-1:0] dmem_rdata_o;
    logic          dmem_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .imem_req_i   (imem_req_i),
        .imem_addr_i  (imem_addr_i),
        .imem_rdata_o (imem_rdata_o),
        .imem_ack_o   (imem_ack_o),
        .dmem_req_i   (dmem_req_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_ack_o   (dmem_ack_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    // ------------------------------------------------------------------
    // Memory: word array, combinational read, ack after stall_target cycles
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [0:16383];
    logic          mem_loaded = 1'b0;
    int            stall_target = 0;
    int            stall_cnt = 0;

    assign mem_ack_i   = mem_req_o && (stall_cnt >= stall_target);
    assign mem_rdata_i = mem[mem_addr_o[15:2]];

    always @(posedge clk_i) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem[14'h0400] <= 32'h1234_5678;   // word at 0x1000
            mem_loaded    <= 1'b1;
        end else if (mem_req_o && mem_ack_i && mem_we_o) begin
            mem[mem_addr_o[15:2]] <= mem_wdata_o;
        end
        if (mem_req_o && !mem_ack_i) stall_cnt <= stall_cnt + 1;
        else                         stall_cnt <= 0;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no ack within %0d cycles, expected one (t=%0t)", name, TIMEOUT, $time);
    endtask

    // Expected outputs for the current cycle
    logic          exp_req, exp_we, exp_iack, exp_dack;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_irdata, exp_drdata;
    bit            m_last_d;     // last winner was the data port
    bit            m_owner_d;    // data port owns the outstanding transaction

    // Observations used by the directed tests
    int            req_cycles = 0;
    int            iack_cnt = 0;
    int            dack_cnt = 0;
    bit            ack_log[$];   // 0 = fetch ack, 1 = data ack
    logic [AW-1:0] seen_addr = '0;
    logic          seen_we = 1'b0;
    logic [DW-1:0] seen_wdata = '0;

    task automatic model_reset();
        exp_req = 0; exp_we = 0; exp_iack = 0; exp_dack = 0;
        exp_addr = '0; exp_wdata = '0; exp_irdata = '0; exp_drdata = '0;
        m_last_d = 1; m_owner_d = 0;
    endtask

    // Predict the outputs of the next cycle from this cycle's activity.
    // A cycle with an ack showing is the response cycle, which always
    // returns to idle; otherwise an outstanding request completes when the
    // memory acks, and with nothing outstanding a new request is granted.
    task automatic model_step();
        if (exp_iack || exp_dack) begin
            exp_iack = 0;
            exp_dack = 0;
        end else if (exp_req) begin
            if (mem_ack_i) begin
                exp_req = 0;
                exp_we  = 0;
                if (m_owner_d) begin exp_dack = 1; exp_drdata = mem_rdata_i; end
                else           begin exp_iack = 1; exp_irdata = mem_rdata_i; end
            end
        end else if (imem_req_i || dmem_req_i) begin
            m_owner_d = imem_req_i ? (dmem_req_i && !m_last_d) : 1'b1;
            m_last_d  = m_owner_d;
            exp_req   = 1;
            exp_we    = m_owner_d && dmem_we_i;
            exp_addr  = m_owner_d ? dmem_addr_i : imem_addr_i;
            exp_wdata = m_owner_d ? dmem_wdata_i : '0;
        end
    endtask

    task automatic compare_all();
        check("mem_req_o", mem_req_o, exp_req);
        check("imem_ack_o", imem_ack_o, exp_iack);
        check("dmem_ack_o", dmem_ack_o, exp_dack);
        check("imem_rdata_o", imem_rdata_o, exp_irdata);
        check("dmem_rdata_o", dmem_rdata_o, exp_drdata);
        if (exp_req) begin
            check("mem_we_o", mem_we_o, exp_we);
            check("mem_addr_o", mem_addr_o, exp_addr);
            check("mem_wdata_o", mem_wdata_o, exp_wdata);
        end
    endtask

    initial begin : compare_proc
        model_reset();
        forever begin
            @(negedge clk_i);
            if (!arst_ni) begin
                model_reset();
                compare_all();
            end else begin
                compare_all();
                if (mem_req_o) begin
                    req_cycles++;
                    seen_addr  = mem_addr_o;
                    seen_we    = mem_we_o;
                    seen_wdata = mem_wdata_o;
                end
                if (imem_ack_o) begin iack_cnt++; ack_log.push_back(1'b0); end
                if (dmem_ack_o) begin dack_cnt++; ack_log.push_back(1'b1); end
                model_step();
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (all input changes happen 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic wait_clk();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        imem_req_i  = 1'b1;
        imem_addr_i = a;
        lat = 0;
        do begin wait_clk(); lat++; end while (!imem_ack_o && lat < TIMEOUT);
        if (!imem_ack_o) timeout_fail("imem_ack_wait");
        d = imem_rdata_o;
        imem_req_i = 1'b0;
    endtask

    task automatic daccess(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           output logic [DW-1:0] d, output int lat);
        dmem_req_i   = 1'b1;
        dmem_we_i    = we;
        dmem_addr_i  = a;
        dmem_wdata_i = wd;
        lat = 0;
        do begin wait_clk(); lat++; end while (!dmem_ack_o && lat < TIMEOUT);
        if (!dmem_ack_o) timeout_fail("dmem_ack_wait");
        d = dmem_rdata_o;
        dmem_req_i = 1'b0;
        dmem_we_i  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stim
        logic [DW-1:0] rd;
        int            lat;
        int            base;
        bit            exp_seq [6];

        // Reset state
        repeat (3) wait_clk();
        check("reset_mem_req", mem_req_o, 1'b0);
        check("reset_mem_addr", mem_addr_o, '0);
        check("reset_acks", {imem_ack_o, dmem_ack_o}, 2'b00);
        arst_ni = 1'b1;
        wait_clk();

        // Tie straight after reset: fetch first, then strict alternation
        stall_target = 1;
        ack_log.delete();
        fork
            begin : tie_i
                logic [DW-1:0] di;
                int            li;
                for (int i = 0; i < 3; i++) fetch(32'h0000_6000 + 4 * i, di, li);
            end
            begin : tie_d
                logic [DW-1:0] dd;
                int            ld;
                for (int j = 0; j < 3; j++) daccess(1'b0, 32'h0000_5000 + 4 * j, '0, dd, ld);
            end
        join
        wait_clk();
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        check("tie_ack_count", ack_log.size(), 6);
        for (int k = 0; k < 6 && k < ack_log.size(); k++)
            check($sformatf("tie_order[%0d]", k), ack_log[k], exp_seq[k]);

        // Single fetch with combinational ack
        stall_target = 0;
        wait_clk();
        req_cycles = 0;
        fetch(32'h0000_1000, rd, lat);
        check("fetch_latency", lat, 2);
        check("fetch_rdata", rd, 32'h1234_5678);
        check("fetch_addr", seen_addr, 32'h0000_1000);
        check("fetch_we", seen_we, 1'b0);
        wait_clk();
        check("fetch_req_cycles", req_cycles, 1);

        // Write, then read back through the fetch port
        wait_clk();
        base = dack_cnt;
        daccess(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, rd, lat);
        check("write_latency", lat, 2);
        check("write_rdata_old", rd, 32'hC0DE_0800);
        check("write_we", seen_we, 1'b1);
        check("write_wdata", seen_wdata, 32'hDEAD_BEEF);
        wait_clk();
        check("write_ack_pulses", dack_cnt - base, 1);
        fetch(32'h0000_2000, rd, lat);
        check("readback_rdata", rd, 32'hDEAD_BEEF);

        // Memory stalls for 5 cycles
        stall_target = 5;
        wait_clk();
        req_cycles = 0;
        base = iack_cnt;
        fetch(32'h0000_1000, rd, lat);
        check("stall_latency", lat, 7);
        repeat (3) wait_clk();
        check("stall_req_cycles", req_cycles, 6);
        check("stall_ack_pulses", iack_cnt - base, 1);

        // Payload changes while busy are ignored
        stall_target = 3;
        dmem_req_i  = 1'b1;
        dmem_we_i   = 1'b0;
        dmem_addr_i = 32'h0000_3000;
        repeat (2) wait_clk();
        dmem_addr_i = 32'h0000_4000;
        lat = 0;
        do begin wait_clk(); lat++; end while (!dmem_ack_o && lat < TIMEOUT);
        if (!dmem_ack_o) timeout_fail("payload_ack_wait");
        check("payload_addr_frozen", seen_addr, 32'h0000_3000);
        check("payload_rdata", dmem_rdata_o, 32'hC0DE_0C00);
        dmem_req_i = 1'b0;
        repeat (2) wait_clk();

        // Reset while busy: outputs clear at once, no ack, fresh grant later
        stall_target = 10;
        dmem_req_i  = 1'b1;
        dmem_addr_i = 32'h0000_1000;
        repeat (3) wait_clk();
        check("pre_reset_busy", mem_req_o, 1'b1);
        base = dack_cnt;
        arst_ni = 1'b0;
        #1;
        check("async_reset_req", mem_req_o, 1'b0);
        check("async_reset_addr", mem_addr_o, '0);
        check("async_reset_acks", {imem_ack_o, dmem_ack_o}, 2'b00);
        check("async_reset_rdata", {imem_rdata_o, dmem_rdata_o}, 64'h0);
        repeat (2) wait_clk();
        stall_target = 0;
        arst_ni = 1'b1;
        lat = 0;
        do begin wait_clk(); lat++; end while (!dmem_ack_o && lat < TIMEOUT);
        if (!dmem_ack_o) timeout_fail("post_reset_ack_wait");
        check("post_reset_latency", lat, 2);
        check("post_reset_rdata", dmem_rdata_o, 32'h1234_5678);
        check("reset_no_extra_ack", dack_cnt - base, 0);
        dmem_req_i = 1'b0;
        repeat (3) wait_clk();
        check("post_reset_ack_once", dack_cnt - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port arst_ni  input  1  asynchronous reset, active low.
REQ-005 SHALL have port imem_req_i  input  1  instruction fetch request, read only.
REQ-006 SHALL have port imem_addr_i  input  ADDR_WIDTH  fetch address.
REQ-007 SHALL have port imem_rdata_o  output  DATA_WIDTH  fetch data, valid while imem_ack_o is high.
REQ-008 SHALL have port imem_ack_o  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port dmem_req_i  input  1  data request.
REQ-010 SHALL have port dmem_we_i  input  1  data write enable.
REQ-011 SHALL have port dmem_addr_i  input  ADDR_WIDTH  data address.
REQ-012 SHALL have port dmem_wdata_i  input  DATA_WIDTH  write data.
REQ-013 SHALL have port dmem_rdata_o  output  DATA_WIDTH  read data, valid while dmem_ack_o is high.
REQ-014 SHALL have port dmem_ack_o  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port mem_req_o  output  1  request to the shared single-port memory.
REQ-016 SHALL have port mem_we_o  output  1  write enable to memory.
REQ-017 SHALL have port mem_addr_o  output  ADDR_WIDTH  memory address.
REQ-018 SHALL have port mem_wdata_o  output  DATA_WIDTH  memory write data.
REQ-019 SHALL have port mem_rdata_i  input  DATA_WIDTH  memory read data, valid while mem_ack_i is high.
REQ-020 SHALL have port mem_ack_i  input  1  memory completion; may be high in the first cycle of mem_req_o (combinational ack).

Function
REQ-021 SHALL implement FSM states IDLE, BUSY, RESP; all mem_* and ack/rdata outputs registered.
REQ-022 Requesters SHALL hold req and payload until ack; the arbiter SHALL latch addr/we/wdata at grant and ignore later payload changes.
REQ-023 In IDLE, with exactly one req high, SHALL grant it; with neither high, SHALL stay IDLE.
REQ-024 In IDLE, with both reqs high, SHALL grant the port not granted last (last_grant flag, reset value DMEM, so the first tie goes to IMEM).
REQ-025 On grant (IDLE at edge N), SHALL enter BUSY, drive mem_req_o=1 with latched payload from N+1; IMEM grants drive mem_we_o=0, mem_wdata_o=0.
REQ-026 In BUSY, mem_req_o and payload SHALL stay constant until a cycle with mem_ack_i=1; wait length is unbounded.
REQ-027 On mem_ack_i in BUSY (cycle M), SHALL capture mem_rdata_i, enter RESP, drop mem_req_o at M+1.
REQ-028 In RESP (cycle M+1), SHALL pulse the granted port's ack_o for exactly one cycle with rdata_o = captured data; the other port's ack_o SHALL stay 0.
REQ-029 RESP SHALL always go to IDLE next cycle; minimum request-to-ack latency 2 cycles, back-to-back grant spacing 3 cycles.
REQ-030 A req still high in IDLE after its ack SHALL be treated as a new transaction.
REQ-031 mem_ack_i SHALL be ignored in IDLE and RESP.
REQ-032 rdata_o values SHALL hold their last captured value between acks; for writes, dmem_rdata_o SHALL carry whatever mem_rdata_i held at ack.

Reset
REQ-033 arst_ni low SHALL immediately force IDLE, last_grant=DMEM, and all outputs to 0, independent of clk_i.
REQ-034 Reset during BUSY or RESP SHALL abort the transaction with no ack pulse; after release, pending reqs SHALL be arbitrated afresh.

Verification
REQ-035 Single fetch: imem_req_i=1, imem_addr_i=0x1000, memory word 0x12345678, combinational ack -> mem_req_o high 1 cycle at N+1 with addr 0x1000, imem_ack_o pulse at N+2 with imem_rdata_o=0x12345678.
REQ-036 Write: dmem_req_i=1, we=1, addr=0x2000, wdata=0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF, dmem_ack_o one pulse; subsequent fetch of 0x2000 returns 0xDEADBEEF.
REQ-037 Tie after reset: both reqs held high from the same cycle -> IMEM served first, then DMEM, then IMEM alternating; no port acked twice in a row while the other waits.
REQ-038 Stalled memory: mem_ack_i held low 5 cycles -> mem_req_o and payload stable all 5 cycles, ack_o pulses exactly once, 1 cycle after mem_ack_i.
REQ-039 Payload change: dmem_addr_i changed from 0x3000 to 0x4000 while BUSY -> mem_addr_o stays 0x3000.
REQ-040 Reset mid-transaction: arst_ni low during BUSY -> all outputs 0 immediately, no ack pulse; after release, held req granted with fresh 2-cycle latency.
